rr_stats: RTL and testbench
===========================

Name: rr_stats

Overview:
- Downstream consumer of the detector core's RR output (rr_period / rr_period_updated).
- Keeps a ring buffer of the last N_AVG RR intervals and maintains a running sum and mean.
- Converts the mean to heart rate in BPM with a sequential restoring divider.
- Flags beats whose RR deviates strongly from the current mean.

Parameters:
- DATA_WIDTH, 11: width of RR period in samples.
- FS, 360: sampling rate in Hz. Dividend constant is 60*FS.
- N_AVG, 8: averaging depth. Must be a power of two, range 2..64.
- BPM_WIDTH, 8: width of BPM output.

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  asynchronous active-low reset
- i_ce  in  1  clock enable; no state changes when low
- i_rr_period  in  DATA_WIDTH  RR interval in samples (unsigned)
- i_rr_period_updated  in  1  one-cycle strobe; i_rr_period is valid this cycle
- o_mean_rr  out  DATA_WIDTH  mean of last N_AVG intervals
- o_mean_valid  out  1  high once buffer holds N_AVG entries
- o_bpm  out  BPM_WIDTH  heart rate, beats per minute
- o_bpm_updated  out  1  one-cycle strobe when o_bpm changes value
- o_irregular  out  1  one-cycle strobe: accepted RR deviates from mean by more than mean/4
- o_overrun  out  1  one-cycle strobe: pending RR overwritten before it was consumed
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: single clock i_clk; asynchronous active-low reset i_nrst.
- Reset values: all outputs 0. Buffer, sum, count, pending flag and FSM (IDLE) are cleared. Reset mid-division aborts with no o_bpm_updated.
- Gating: everything advances only on i_ce=1 edges. Latencies below are counted in ce-cycles.
- Widths:
  - SUM_W = DATA_WIDTH + log2(N_AVG).
  - NUM = 60*FS; NUM_W = bits of NUM (15 for FS=360).
  - The divider remainder is NUM_W+1 bits.
- FSM states: IDLE, ACCUM, DIVIDE, DONE.
- IDLE: on strobe, capture i_rr_period into rr_in and go to ACCUM.
- ACCUM (1 cycle):
  - If count==N_AVG: o_irregular = (|rr_in - o_mean_rr| > o_mean_rr>>2), using the pre-update mean.
  - Write rr_in at the write pointer (wraps modulo N_AVG).
  - sum <= sum + rr_in - oldest. The oldest entry reads as 0 while count<N_AVG.
  - count saturates at N_AVG.
  - Next state: DIVIDE if the new count==N_AVG, else IDLE.
- Mean update: o_mean_rr is registered from (new sum >> log2(N_AVG)) at the end of ACCUM. o_mean_valid rises in the same cycle count reaches N_AVG.
- DIVIDE: restoring division NUM / o_mean_rr, one quotient bit per cycle, NUM_W cycles.
- DONE (1 cycle):
  - o_bpm <= min(quotient, 2^BPM_WIDTH-1).
  - Divisor 0: force o_bpm to all-ones.
  - Pulse o_bpm_updated.
  - Next state: IDLE.
- Latency: strobe accepted at edge t gives ACCUM at t+1, DIVIDE t+2..t+1+NUM_W, DONE at t+2+NUM_W (17 for defaults).
- Strobe while not IDLE:
  - Store into pending register and set pending.
  - If pending was already set, overwrite it and pulse o_overrun.
  - On return to IDLE with pending set, take the pending value (pending cleared) instead of waiting for a new strobe.
  - A strobe arriving in the same cycle as pending is consumed: the new value is kept as pending, with no overrun pulse.
- Strobe with i_ce=0: ignored (not captured).
- Arithmetic: all arithmetic is unsigned, and i_rr_period is treated as unsigned.

Optional Feature:
- Macro: RR_STATS_RANGE_CHECK_EN.
- Defined:
  - In IDLE, a captured RR below FS/5 (>300 bpm) or above 2*FS (<30 bpm) is rejected.
  - Rejection drops the value with no buffer write and no ACCUM.
  - It raises extra output o_rr_rejected (1 bit) for one cycle, 1 cycle after capture.
  - o_rr_rejected resets to 0.
- Undefined: port o_rr_rejected is absent, and all values are accepted.

Test Plan:
- Reset, then 8 strobes rr=360 spaced 20 cycles apart -> o_mean_valid rises on the 8th ACCUM; o_mean_rr=360; o_bpm=60 with o_bpm_updated 17 cycles after the 8th strobe; o_irregular never pulses.
- Buffer full of 360, then 8 strobes rr=288 -> mean steps by 9 per strobe down to 288; final o_bpm=75.
- Buffer full of 360, one strobe rr=250 -> o_irregular pulse (|110|>90); mean=346; o_bpm=62.
- Buffer full, three strobes 2 cycles apart (300,310,320) -> o_overrun pulses once; 300 and 320 are processed and 310 is discarded; two o_bpm_updated pulses.
- Assert i_nrst low at DIVIDE cycle 5 -> all outputs 0, no o_bpm_updated; next full fill of 8×360 gives o_bpm=60.
- With RR_STATS_RANGE_CHECK_EN, strobe rr=50 -> o_rr_rejected pulse; count, sum and o_mean_rr unchanged. Without the macro, the same value is accepted.

Source files
------------

// File: rtl/rr_stats_if.sv
// Bus bundle for rr_stats: RR input strobe/value plus all statistics outputs.
// Ports: i_ce, i_rr_period, i_rr_period_updated in; o_mean_rr, o_mean_valid,
//   o_bpm, o_bpm_updated, o_irregular, o_overrun, o_busy (+ o_rr_rejected with RR_STATS_RANGE_CHECK_EN) out.
// master = RR source / observer side, slave = rr_stats side.
interface rr_stats_if #(
  parameter int DATA_WIDTH = 11,
  parameter int BPM_WIDTH  = 8
);
  logic                  i_ce;
  logic [DATA_WIDTH-1:0] i_rr_period;
  logic                  i_rr_period_updated;
  logic [DATA_WIDTH-1:0] o_mean_rr;
  logic                  o_mean_valid;
  logic [BPM_WIDTH-1:0]  o_bpm;
  logic                  o_bpm_updated;
  logic                  o_irregular;
  logic                  o_overrun;
  logic                  o_busy;
`ifdef RR_STATS_RANGE_CHECK_EN
  logic                  o_rr_rejected;
`endif

  modport master (
    output i_ce, i_rr_period, i_rr_period_updated,
    input  o_mean_rr, o_mean_valid, o_bpm, o_bpm_updated, o_irregular, o_overrun, o_busy
`ifdef RR_STATS_RANGE_CHECK_EN
    , input o_rr_rejected
`endif
  );

  modport slave (
    input  i_ce, i_rr_period, i_rr_period_updated,
    output o_mean_rr, o_mean_valid, o_bpm, o_bpm_updated, o_irregular, o_overrun, o_busy
`ifdef RR_STATS_RANGE_CHECK_EN
    , output o_rr_rejected
`endif
  );
endinterface

// File: rtl/rr_stats.sv
// RR statistics: ring buffer of the last N_AVG RR intervals, running sum/mean,
// BPM = 60*FS/mean via a 1-bit/cycle restoring divider, irregular-beat and overrun flags.
// Ports: i_clk, i_nrst (async active-low), bus (rr_stats_if.slave). Interface params must match DATA_WIDTH/BPM_WIDTH.
// Optional macro RR_STATS_RANGE_CHECK_EN: reject RR outside [FS/5, 2*FS] and pulse o_rr_rejected.
// Latency (ce-cycles): strobe at t -> mean at t+1, o_bpm_updated at t+2+NUM_W. One RR can wait in a pending slot.
module rr_stats #(
  parameter int DATA_WIDTH = 11,
  parameter int FS         = 360,
  parameter int N_AVG      = 8,
  parameter int BPM_WIDTH  = 8
) (
  input logic     i_clk,
  input logic     i_nrst,
  rr_stats_if.slave bus
);
  localparam int LOG2N = $clog2(N_AVG);
  localparam int SUM_W = DATA_WIDTH + LOG2N;
  localparam int NUM   = 60 * FS;
  localparam int NUM_W = $clog2(NUM + 1);
  // Trial remainder must hold any divisor value as well as NUM_W+1 bits of shifted remainder.
  localparam int DIV_W = ((NUM_W > DATA_WIDTH) ? NUM_W : DATA_WIDTH) + 1;
  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [NUM_W-1:0] NUM_C     = NUM_W'(NUM);
  localparam logic [NUM_W-1:0] BPM_MAX_Q = NUM_W'(2 ** BPM_WIDTH - 1);
  localparam logic [LOG2N:0]   FULL      = (LOG2N + 1)'(N_AVG);
`ifdef RR_STATS_RANGE_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] RR_MIN = DATA_WIDTH'(FS / 5);
  localparam logic [DATA_WIDTH-1:0] RR_MAX = DATA_WIDTH'(2 * FS);
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] rr_in;
  logic                  pend_vld;
  logic [DATA_WIDTH-1:0] pend_rr;
  logic [DATA_WIDTH-1:0] buf_mem [N_AVG];
  logic [LOG2N-1:0]      wr_ptr;
  logic [LOG2N:0]        count;
  logic [SUM_W-1:0]      sum;
  logic [NUM_W-1:0]      quo;    // holds remaining dividend bits at the top, quotient shifts in at the bottom
  logic [DIV_W-2:0]      rem;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] mean_rr;
  logic                  mean_valid, bpm_updated, irregular, overrun;
  logic [BPM_WIDTH-1:0]  bpm;
`ifdef RR_STATS_RANGE_CHECK_EN
  logic                  rr_rejected;
  assign bus.o_rr_rejected = rr_rejected;
`endif

  logic [DATA_WIDTH-1:0] oldest, rr_diff, cand;
  logic [SUM_W-1:0]      sum_next;
  logic [LOG2N:0]        count_next;
  logic [DIV_W-1:0]      trial, divisor;
  logic                  trial_ge;

  always_comb begin
    // Slots not yet filled since reset contribute nothing to the sum.
    oldest     = (count == FULL) ? buf_mem[wr_ptr] : '0;
    sum_next   = sum + SUM_W'(rr_in) - SUM_W'(oldest);
    count_next = (count == FULL) ? FULL : count + 1'b1;
    rr_diff    = (rr_in >= mean_rr) ? rr_in - mean_rr : mean_rr - rr_in;
    trial      = {rem, quo[NUM_W-1]};
    divisor    = DIV_W'(mean_rr);
    trial_ge   = trial >= divisor;
    // A pending RR always goes ahead of a fresh strobe.
    cand       = pend_vld ? pend_rr : bus.i_rr_period;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state       <= IDLE;
      rr_in       <= '0;
      pend_vld    <= 1'b0;
      pend_rr     <= '0;
      for (int i = 0; i < N_AVG; i++) buf_mem[i] <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      sum         <= '0;
      quo         <= '0;
      rem         <= '0;
      bit_cnt     <= '0;
      mean_rr     <= '0;
      mean_valid  <= 1'b0;
      bpm         <= '0;
      bpm_updated <= 1'b0;
      irregular   <= 1'b0;
      overrun     <= 1'b0;
`ifdef RR_STATS_RANGE_CHECK_EN
      rr_rejected <= 1'b0;
`endif
    end else if (bus.i_ce) begin
      bpm_updated <= 1'b0;
      irregular   <= 1'b0;
      overrun     <= 1'b0;
`ifdef RR_STATS_RANGE_CHECK_EN
      rr_rejected <= 1'b0;
`endif
      if (state != IDLE && bus.i_rr_period_updated) begin
        pend_rr  <= bus.i_rr_period;
        pend_vld <= 1'b1;
        overrun  <= pend_vld;
      end

      case (state)
        IDLE: begin
          if (pend_vld) begin
            // Pending slot is drained; a simultaneous strobe refills it without overrun.
            pend_vld <= bus.i_rr_period_updated;
            if (bus.i_rr_period_updated) pend_rr <= bus.i_rr_period;
          end
          if (pend_vld || bus.i_rr_period_updated) begin
`ifdef RR_STATS_RANGE_CHECK_EN
            if (cand < RR_MIN || cand > RR_MAX) begin
              rr_rejected <= 1'b1;
            end else begin
              rr_in <= cand;
              state <= ACCUM;
            end
`else
            rr_in <= cand;
            state <= ACCUM;
`endif
          end
        end
        ACCUM: begin
          irregular       <= (count == FULL) && (rr_diff > (mean_rr >> 2));
          buf_mem[wr_ptr] <= rr_in;
          wr_ptr          <= wr_ptr + 1'b1;
          sum             <= sum_next;
          count           <= count_next;
          mean_rr         <= sum_next[SUM_W-1:LOG2N];
          mean_valid      <= (count_next == FULL);
          if (count_next == FULL) begin
            quo     <= NUM_C;
            rem     <= '0;
            bit_cnt <= CNT_W'(NUM_W - 1);
            state   <= DIVIDE;
          end else begin
            state   <= IDLE;
          end
        end
        DIVIDE: begin
          rem     <= trial_ge ? (DIV_W - 1)'(trial - divisor) : trial[DIV_W-2:0];
          quo     <= {quo[NUM_W-2:0], trial_ge};
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == '0) state <= DONE;
        end
        DONE: begin
          if (mean_rr == '0 || quo > BPM_MAX_Q) bpm <= '1;
          else                                   bpm <= BPM_WIDTH'(quo);
          bpm_updated <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_mean_rr     = mean_rr;
  assign bus.o_mean_valid  = mean_valid;
  assign bus.o_bpm         = bpm;
  assign bus.o_bpm_updated = bpm_updated;
  assign bus.o_irregular   = irregular;
  assign bus.o_overrun     = overrun;
  assign bus.o_busy        = (state != IDLE);
endmodule

// File: tb/tb_rr_stats.sv
// Directed bench for rr_stats: fill/mean/BPM, stepping mean, irregular beat,
// overrun, clock-enable gating, reset mid-division and out-of-range RR.
module tb_rr_stats;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  rr_stats_if io ();
  rr_stats dut (.i_clk(clk), .i_nrst(nrst), .bus(io));

  int total = 0, bad = 0;
  int cyc = 0, s_cyc = 0, upd_cyc = 0;
  int n_upd = 0, n_irr = 0, n_ovr = 0, n_rej = 0;

  // One clock; outputs sampled 1 time unit after the edge, pulses counted.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (io.o_bpm_updated) begin n_upd++; upd_cyc = cyc; end
    if (io.o_irregular) n_irr++;
    if (io.o_overrun) n_ovr++;
`ifdef RR_STATS_RANGE_CHECK_EN
    if (io.o_rr_rejected) n_rej++;
`endif
  endtask

  task automatic strobe(input int v);
    io.i_rr_period = 11'(v);
    io.i_rr_period_updated = 1'b1;
    tick();
    s_cyc = cyc;
    io.i_rr_period_updated = 1'b0;
  endtask

  task automatic wait_upd(input int start);
    for (int k = 0; k < 40 && n_upd == start; k++) tick();
  endtask

  task automatic refill(input int v);
    for (int i = 0; i < 8; i++) begin
      strobe(v);
      repeat (19) tick();
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) tick();
    total++; if (io.o_mean_rr !== 11'd0) begin bad++; $display("FAIL reset_mean: got %0d want 0", io.o_mean_rr); end
    total++; if (io.o_bpm !== 8'd0) begin bad++; $display("FAIL reset_bpm: got %0d want 0", io.o_bpm); end
    total++; if ({io.o_mean_valid, io.o_bpm_updated, io.o_irregular, io.o_overrun, io.o_busy} !== 5'b0)
      begin bad++; $display("FAIL reset_flags: got %b want 00000", {io.o_mean_valid, io.o_bpm_updated, io.o_irregular, io.o_overrun, io.o_busy}); end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    int u0 = n_upd, i0 = n_irr;
    for (int i = 0; i < 8; i++) begin
      strobe(360);
      total++; if (io.o_busy !== 1'b1) begin bad++; $display("FAIL fill_busy[%0d]: got %b want 1", i, io.o_busy); end
      tick();
      total++; if (io.o_mean_valid !== 1'(i == 7)) begin bad++; $display("FAIL fill_valid[%0d]: got %b want %b", i, io.o_mean_valid, (i == 7)); end
      if (i < 7) repeat (18) tick();
    end
    wait_upd(u0);
    total++; if (n_upd - u0 !== 1) begin bad++; $display("FAIL fill_upd_count: got %0d want 1", n_upd - u0); end
    total++; if (upd_cyc - s_cyc !== 17) begin bad++; $display("FAIL fill_latency: got %0d want 17", upd_cyc - s_cyc); end
    total++; if (io.o_bpm !== 8'd60) begin bad++; $display("FAIL fill_bpm: got %0d want 60", io.o_bpm); end
    total++; if (io.o_mean_rr !== 11'd360) begin bad++; $display("FAIL fill_mean: got %0d want 360", io.o_mean_rr); end
    total++; if (n_irr !== i0) begin bad++; $display("FAIL fill_irregular: got %0d pulses want 0", n_irr - i0); end
    repeat (3) tick();
  endtask

  task automatic test_step();
    int i0 = n_irr;
    for (int i = 0; i < 8; i++) begin
      strobe(288);
      tick();
      total++; if (io.o_mean_rr !== 11'(351 - 9 * i)) begin bad++; $display("FAIL step_mean[%0d]: got %0d want %0d", i, io.o_mean_rr, 351 - 9 * i); end
      repeat (18) tick();
    end
    total++; if (io.o_bpm !== 8'd75) begin bad++; $display("FAIL step_bpm: got %0d want 75", io.o_bpm); end
    total++; if (n_irr !== i0) begin bad++; $display("FAIL step_irregular: got %0d pulses want 0", n_irr - i0); end
  endtask

  task automatic test_irregular();
    int i0;
    refill(360);
    total++; if (io.o_bpm !== 8'd60) begin bad++; $display("FAIL irr_pre_bpm: got %0d want 60", io.o_bpm); end
    i0 = n_irr;
    strobe(250);
    tick();
    total++; if (io.o_irregular !== 1'b1) begin bad++; $display("FAIL irr_pulse: got %b want 1", io.o_irregular); end
    total++; if (io.o_mean_rr !== 11'd346) begin bad++; $display("FAIL irr_mean: got %0d want 346", io.o_mean_rr); end
    repeat (18) tick();
    total++; if (io.o_bpm !== 8'd62) begin bad++; $display("FAIL irr_bpm: got %0d want 62", io.o_bpm); end
    total++; if (n_irr - i0 !== 1) begin bad++; $display("FAIL irr_count: got %0d want 1", n_irr - i0); end
  endtask

  task automatic test_overrun();
    int u0, o0;
    refill(360);
    u0 = n_upd; o0 = n_ovr;
    strobe(300); tick();
    strobe(310); tick();
    strobe(320);
    total++; if (io.o_overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %b want 1", io.o_overrun); end
    repeat (50) tick();
    total++; if (n_ovr - o0 !== 1) begin bad++; $display("FAIL ovr_count: got %0d want 1", n_ovr - o0); end
    total++; if (n_upd - u0 !== 2) begin bad++; $display("FAIL ovr_upd_count: got %0d want 2", n_upd - u0); end
    total++; if (io.o_mean_rr !== 11'd347) begin bad++; $display("FAIL ovr_mean: got %0d want 347", io.o_mean_rr); end
    total++; if (io.o_bpm !== 8'd62) begin bad++; $display("FAIL ovr_bpm: got %0d want 62", io.o_bpm); end
    total++; if (io.o_busy !== 1'b0) begin bad++; $display("FAIL ovr_idle: got %b want 0", io.o_busy); end
  endtask

  task automatic test_ce();
    int u0 = n_upd;
    io.i_ce = 1'b0;
    strobe(100);
    io.i_ce = 1'b1;
    repeat (25) tick();
    total++; if (n_upd !== u0) begin bad++; $display("FAIL ce_ignored_upd: got %0d want 0", n_upd - u0); end
    total++; if (io.o_mean_rr !== 11'd347) begin bad++; $display("FAIL ce_ignored_mean: got %0d want 347", io.o_mean_rr); end
    // Stall the divider 5 ce-cycles; the update moves out by the same amount.
    strobe(360);
    repeat (3) tick();
    io.i_ce = 1'b0;
    repeat (5) tick();
    io.i_ce = 1'b1;
    wait_upd(u0);
    total++; if (upd_cyc - s_cyc !== 22) begin bad++; $display("FAIL ce_stall_latency: got %0d want 22", upd_cyc - s_cyc); end
    total++; if (io.o_bpm !== 8'd62) begin bad++; $display("FAIL ce_stall_bpm: got %0d want 62", io.o_bpm); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_div();
    int u0;
    strobe(360);
    repeat (6) tick();
    total++; if (io.o_busy !== 1'b1) begin bad++; $display("FAIL rstdiv_busy: got %b want 1", io.o_busy); end
    u0 = n_upd;
    nrst = 1'b0;
    #1;
    total++; if ({io.o_mean_rr, io.o_bpm} !== 19'd0) begin bad++; $display("FAIL rstdiv_values: got mean=%0d bpm=%0d want 0", io.o_mean_rr, io.o_bpm); end
    total++; if ({io.o_mean_valid, io.o_bpm_updated, io.o_irregular, io.o_overrun, io.o_busy} !== 5'b0)
      begin bad++; $display("FAIL rstdiv_flags: got %b want 00000", {io.o_mean_valid, io.o_bpm_updated, io.o_irregular, io.o_overrun, io.o_busy}); end
    repeat (2) tick();
    nrst = 1'b1;
    repeat (25) tick();
    total++; if (n_upd !== u0) begin bad++; $display("FAIL rstdiv_no_upd: got %0d want 0", n_upd - u0); end
    test_fill();
  endtask

  task automatic test_small_rr();
    int u0 = n_upd, r0 = n_rej, i0 = n_irr;
    strobe(50);
`ifdef RR_STATS_RANGE_CHECK_EN
    total++; if (io.o_rr_rejected !== 1'b1) begin bad++; $display("FAIL rej_pulse: got %b want 1", io.o_rr_rejected); end
    tick();
    total++; if (io.o_mean_rr !== 11'd360) begin bad++; $display("FAIL rej_mean: got %0d want 360", io.o_mean_rr); end
    repeat (20) tick();
    total++; if (n_rej - r0 !== 1) begin bad++; $display("FAIL rej_count: got %0d want 1", n_rej - r0); end
    total++; if (n_upd !== u0) begin bad++; $display("FAIL rej_no_upd: got %0d want 0", n_upd - u0); end
    total++; if (io.o_bpm !== 8'd60) begin bad++; $display("FAIL rej_bpm: got %0d want 60", io.o_bpm); end
`else
    tick();
    total++; if (io.o_mean_rr !== 11'd321) begin bad++; $display("FAIL small_mean: got %0d want 321", io.o_mean_rr); end
    total++; if (n_irr - i0 !== 1) begin bad++; $display("FAIL small_irregular: got %0d want 1", n_irr - i0); end
    repeat (20) tick();
    total++; if (n_upd - u0 !== 1) begin bad++; $display("FAIL small_upd: got %0d want 1", n_upd - u0); end
    total++; if (io.o_bpm !== 8'd67) begin bad++; $display("FAIL small_bpm: got %0d want 67", io.o_bpm); end
    total++; if (n_rej !== r0) begin bad++; $display("FAIL small_rej: got %0d want 0", n_rej - r0); end
`endif
  endtask

  initial begin
    io.i_ce = 1'b1;
    io.i_rr_period = '0;
    io.i_rr_period_updated = 1'b0;
    test_reset();
    test_fill();
    test_step();
    test_irregular();
    test_overrun();
    test_ce();
    test_reset_mid_div();
    test_small_rr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
